// File: rtl/nmc_launch_ctrl.sv
// NM-Carus kernel launcher: BOOT_PC -> FETCH_EN -> START -> wait DONE, timed and watchdogged.
// START pulses CfgSetupCycles+1 cycles after accept; response holds until rsp_ready_i, one launch at a time.
module nmc_launch_ctrl #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned CntWidth       = 32,
  parameter int unsigned TimeoutCycles  = 100000,
  parameter int unsigned CfgSetupCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_boot_pc_i,
  input  logic                 abort_i,
  output logic [AddrWidth-1:0] carus_boot_pc_o,
  output logic                 carus_fetch_en_o,
  output logic                 carus_start_o,
  input  logic                 carus_done_i,
  output logic                 busy_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [1:0]           rsp_status_o,
  output logic [CntWidth-1:0]  rsp_cycles_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusTimeout = 2'b01;
  localparam logic [1:0] StatusAborted = 2'b10;

  localparam int unsigned SetupWidth = (CfgSetupCycles > 1) ? $clog2(CfgSetupCycles) : 1;
  localparam logic [SetupWidth-1:0] SetupLast = SetupWidth'(CfgSetupCycles - 1);
  localparam logic [CntWidth-1:0]   CntMax    = {CntWidth{1'b1}};
  localparam bit                    TimeoutEn = (TimeoutCycles != 0);
  localparam logic [63:0]           TimeoutVal = 64'(TimeoutCycles);

  state_e                 state_q, state_d;
  logic [SetupWidth-1:0]  setup_q, setup_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [1:0]             status_q, status_d;
  logic [AddrWidth-1:0]   boot_pc_q, boot_pc_d;
  logic                   timeout_hit;

  // Compared at full width so a limit above the counter range simply never fires.
  assign timeout_hit = TimeoutEn && (64'(cnt_q) == TimeoutVal);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    setup_d   = setup_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    boot_pc_d = boot_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          boot_pc_d = req_boot_pc_i;
          cnt_d     = '0;
          setup_d   = '0;
          state_d   = ST_CFG;
        end
      end
      ST_CFG: begin
        if (abort_i) begin
          status_d = StatusAborted;
          state_d  = ST_RESP;
        end else if (setup_q == SetupLast) begin
          state_d = ST_START;
        end else begin
          setup_d = setup_q + SetupWidth'(1);
        end
      end
      ST_START: begin
        cnt_d   = CntWidth'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // DONE wins over abort, abort wins over the watchdog; the count freezes on exit.
        if (carus_done_i) begin
          status_d = StatusOk;
          state_d  = ST_RESP;
        end else if (abort_i) begin
          status_d = StatusAborted;
          state_d  = ST_RESP;
        end else if (timeout_hit) begin
          status_d = StatusTimeout;
          state_d  = ST_RESP;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      setup_q          <= '0;
      cnt_q            <= '0;
      status_q         <= StatusOk;
      boot_pc_q        <= '0;
      req_ready_o      <= 1'b1;
      carus_fetch_en_o <= 1'b0;
      carus_start_o    <= 1'b0;
      busy_o           <= 1'b0;
      rsp_valid_o      <= 1'b0;
    end else begin
      setup_q          <= setup_d;
      cnt_q            <= cnt_d;
      status_q         <= status_d;
      boot_pc_q        <= boot_pc_d;
      req_ready_o      <= (state_d == ST_IDLE);
      carus_fetch_en_o <= (state_d == ST_CFG) || (state_d == ST_START) || (state_d == ST_RUN);
      carus_start_o    <= (state_d == ST_START);
      busy_o           <= (state_d != ST_IDLE);
      rsp_valid_o      <= (state_d == ST_RESP);
    end
  end

  assign carus_boot_pc_o = boot_pc_q;
  assign rsp_status_o    = status_q;
  assign rsp_cycles_o    = cnt_q;

endmodule

// File: tb/tb_nmc_launch_ctrl.sv
// Bench for nmc_launch_ctrl: directed and random launches checked against a timeline model.
module tb_nmc_launch_ctrl;

  localparam int S   = 2;
  localparam int T   = 100;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, abort, fetch_en, start, done, busy, rsp_valid, rsp_ready;
  logic [31:0] pc, boot_pc, cycles;
  logic [1:0]  status;

  logic        b_req_valid, b_req_ready, b_abort, b_fetch_en, b_start, b_done, b_busy;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_pc, b_boot_pc;
  logic [1:0]  b_status;
  logic [3:0]  b_cycles;

  int total = 0;
  int bad   = 0;

  nmc_launch_ctrl #(
    .AddrWidth(32), .CntWidth(32), .TimeoutCycles(T), .CfgSetupCycles(S)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_boot_pc_i(pc),
    .abort_i(abort),
    .carus_boot_pc_o(boot_pc), .carus_fetch_en_o(fetch_en), .carus_start_o(start),
    .carus_done_i(done), .busy_o(busy),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_status_o(status), .rsp_cycles_o(cycles)
  );

  nmc_launch_ctrl #(
    .AddrWidth(32), .CntWidth(4), .TimeoutCycles(0), .CfgSetupCycles(S)
  ) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_boot_pc_i(b_pc),
    .abort_i(b_abort),
    .carus_boot_pc_o(b_boot_pc), .carus_fetch_en_o(b_fetch_en), .carus_start_o(b_start),
    .carus_done_i(b_done), .busy_o(b_busy),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_status_o(b_status), .rsp_cycles_o(b_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 = accept cycle; RUN cycle k (count k) sits at absolute cycle S+1+k.
  // Inputs are level-held from their absolute start cycle until the response handshake.
  task automatic launch(input logic [31:0] p, input int done_from, input int abort_from,
                        input int wait_n, input bit hold_req, input string tag);
    int kd, ka, kmin, rc_exp, cyc_exp, start_exp, rc_obs, h, n_start, start_cyc;
    logic [1:0]  st_exp, st_rec;
    logic [31:0] cyc_rec;
    bit fe_bad, rdy_bad, hold_bad, finished;
    if (abort_from >= 1 && abort_from <= S) begin
      st_exp = 2'b10; cyc_exp = 0; rc_exp = abort_from + 1; start_exp = -1;
    end else begin
      kd = (done_from == 0) ? BIG : ((done_from >= S + 2) ? done_from - (S + 1) : 1);
      ka = (abort_from == 0) ? BIG : ((abort_from >= S + 2) ? abort_from - (S + 1) : 1);
      kmin = T;
      if (ka < kmin) kmin = ka;
      if (kd < kmin) kmin = kd;
      if (kd == kmin)      st_exp = 2'b00;
      else if (ka == kmin) st_exp = 2'b10;
      else                 st_exp = 2'b01;
      cyc_exp = kmin; rc_exp = S + 2 + kmin; start_exp = S + 1;
    end
    chk({tag, "/req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; pc = p; done = 1'b0; abort = 1'b0; rsp_ready = 1'b0;
    rc_obs = -1; h = -1; n_start = 0; start_cyc = -1;
    fe_bad = 0; rdy_bad = 0; hold_bad = 0; finished = 0;
    st_rec = 2'bxx; cyc_rec = 'x;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!hold_req) req_valid = 1'b0;
      if (h >= 0) begin
        chk({tag, "/rsp_valid_after_hs"}, rsp_valid, 0);
        chk({tag, "/req_ready_after_hs"}, req_ready, 1);
        chk({tag, "/busy_after_hs"}, busy, 0);
        chk({tag, "/boot_pc"}, boot_pc, p);
        rsp_ready = 1'b0; done = 1'b0; abort = 1'b0;
        finished = 1;
        break;
      end
      if (start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (rc_obs < 0) begin
        if (rsp_valid) begin
          rc_obs = c; st_rec = status; cyc_rec = cycles;
          chk({tag, "/fetch_en_in_resp"}, fetch_en, 0);
        end else if (!fetch_en) begin
          fe_bad = 1;
        end
      end else if (!rsp_valid || status !== st_rec || cycles !== cyc_rec) begin
        hold_bad = 1;
      end
      if (req_ready) rdy_bad = 1;
      done  = (done_from != 0 && c >= done_from);
      abort = (abort_from != 0 && c >= abort_from);
      if (rc_obs >= 0 && c - rc_obs >= wait_n) begin
        rsp_ready = 1'b1; h = c;
      end
    end
    chk({tag, "/handshake_seen"}, finished, 1);
    chk({tag, "/start_pulses"}, n_start, (start_exp < 0) ? 0 : 1);
    chk({tag, "/start_cycle"}, start_cyc, start_exp);
    chk({tag, "/rsp_cycle"}, rc_obs, rc_exp);
    chk({tag, "/status"}, st_rec, st_exp);
    chk({tag, "/cycles"}, cyc_rec, cyc_exp);
    chk({tag, "/fetch_en_held"}, fe_bad, 0);
    chk({tag, "/rsp_stable"}, hold_bad, 0);
    chk({tag, "/no_early_accept"}, rdy_bad, 0);
  endtask

  task automatic launch_b(input int k, input string tag);
    int rc, cexp;
    logic [1:0] st;
    logic [3:0] cy;
    cexp = (k > 15) ? 15 : k;
    b_req_valid = 1'b1; b_pc = 32'h0000_2000 + k; rc = -1;
    st = 2'bxx; cy = 'x;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      b_req_valid = 1'b0;
      if (b_rsp_valid) begin
        rc = c; st = b_status; cy = b_cycles; b_rsp_ready = 1'b1;
        break;
      end
      b_done = (c >= S + 1 + k);
    end
    @(negedge clk);
    b_rsp_ready = 1'b0; b_done = 1'b0;
    chk({tag, "/rsp_cycle"}, rc, S + 2 + k);
    chk({tag, "/status"}, st, 2'b00);
    chk({tag, "/cycles"}, cy, cexp);
    chk({tag, "/rsp_valid_after_hs"}, b_rsp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; pc = '0; abort = 1'b0; done = 1'b0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_pc = '0; b_abort = 1'b0; b_done = 1'b0; b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/req_ready", req_ready, 1);
    chk("reset/fetch_en", fetch_en, 0);
    chk("reset/start", start, 0);
    chk("reset/busy", busy, 0);
    chk("reset/rsp_valid", rsp_valid, 0);
    chk("reset/status", status, 0);
    chk("reset/cycles", cycles, 0);
    chk("reset/boot_pc", boot_pc, 0);
    rst_n = 1'b1;

    launch(32'h0000_1000, S + 1 + 50, 0, 0, 0, "ok50");
    launch(32'h0000_2000, 0, 0, 0, 0, "timeout");
    launch(32'h0000_3000, 0, 1, 0, 0, "abort_cfg_first");
    launch(32'h0000_3100, 0, S, 1, 0, "abort_cfg_last");
    launch(32'h0000_4000, 20, 20, 1, 0, "done_abort_tie");
    launch(32'h0000_5000, 1, 0, 0, 0, "stale_done");
    launch(32'h0000_5100, 0, S + 1, 0, 0, "abort_in_start");
    launch(32'h0000_6000, 10, 0, 20, 1, "rsp_backpressure");
    launch(32'h0000_7000, 15, 0, 0, 0, "after_held_req");
    launch(32'h0000_8000, 0, 40, 2, 0, "abort_run");
    launch(32'h0000_8100, 0, S + 1 + T, 0, 0, "abort_timeout_tie");

    for (int i = 0; i < 30; i++) begin
      launch($urandom,
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 110),
             ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 110),
             $urandom_range(0, 4), $urandom_range(0, 1) == 1, "random");
    end
    req_valid = 1'b0;
    @(negedge clk);

    req_valid = 1'b1; pc = 32'hdead_beef;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_run/fetch_en_before", fetch_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run/fetch_en", fetch_en, 0);
    chk("rst_run/start", start, 0);
    chk("rst_run/rsp_valid", rsp_valid, 0);
    chk("rst_run/req_ready", req_ready, 1);
    chk("rst_run/busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(32'h0000_9000, S + 1 + 7, 0, 1, 0, "after_reset");

    launch_b(30, "sat30");
    launch_b(12, "sat12");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
